// File: rtl/fc_flatten_pkg.sv
// Shared constants and types for the FC flatten/replay buffer.
package fc_flatten_pkg;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 48;
  localparam int LANES     = 3;
  localparam int BEATS     = FRAME_LEN / LANES;
  localparam int AW        = $clog2(FRAME_LEN);
  localparam int BW        = $clog2(BEATS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic [LANES-1:0][DATA_W-1:0] beat_t;
endpackage

// File: rtl/fc_flatten_bank.sv
// One frame bank: single write port, LANES-wide read of beat i_beat.
module fc_flatten_bank #(
  parameter int DEPTH  = 48,
  parameter int LANES  = 3,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int BW     = $clog2(DEPTH / LANES)
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [AW-1:0]                  i_waddr,
  input  logic [DATA_W-1:0]              i_wdata,
  input  logic [BW-1:0]                  i_beat,
  output logic [LANES-1:0][DATA_W-1:0]   o_lanes
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; full flags gate any reads.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [AW-1:0] w_idx;
    assign w_idx      = AW'(int'(i_beat) * LANES + l);
    assign o_lanes[l] = r_mem[w_idx];
  end
endmodule

// File: rtl/fc_flatten_buffer.sv
// Ping-pong frame buffer: collects FRAME_LEN samples, replays them as
// BEATS beats of LANES values once the FC stage has its weights loaded.
import fc_flatten_pkg::*;

module fc_flatten_buffer (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     fc_ready,
  output logic signed [DATA_W-1:0] data_out_1,
  output logic signed [DATA_W-1:0] data_out_2,
  output logic signed [DATA_W-1:0] data_out_3,
  output logic                     o_valid,
  output logic                     frame_done,
  output logic                     ovf_err
);
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_cnt;
  logic [BW-1:0] r_beat_cnt;
  state_t        r_state;

  logic          w_accept;
  beat_t         w_lanes [2];
  beat_t         w_rd;

  assign in_ready = !r_full[r_wr_bank];
  assign w_accept = in_valid && in_ready;
  assign w_rd     = w_lanes[r_rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fc_flatten_bank #(
      .DEPTH (FRAME_LEN),
      .LANES (LANES),
      .DATA_W(DATA_W)
    ) u_bank (
      .i_clk  (i_clk),
      .i_we   (w_accept && (r_wr_bank == 1'(b))),
      .i_waddr(r_wr_cnt),
      .i_wdata(in_data),
      .i_beat (r_beat_cnt),
      .o_lanes(w_lanes[b])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_beat_cnt <= '0;
      r_state    <= IDLE;
      data_out_1 <= '0;
      data_out_2 <= '0;
      data_out_3 <= '0;
      o_valid    <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_wr_cnt == AW'(FRAME_LEN - 1)) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_cnt          <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (in_valid && !in_ready) ovf_err <= 1'b1;

      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          o_valid <= 1'b0;
          // !o_valid forces one low cycle after a frame before the next starts.
          if (r_full[r_rd_bank] && fc_ready && !o_valid) begin
            data_out_1 <= w_rd[0];
            data_out_2 <= w_rd[1];
            data_out_3 <= w_rd[2];
            o_valid    <= 1'b1;
            r_beat_cnt <= BW'(1);
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          data_out_1 <= w_rd[0];
          data_out_2 <= w_rd[1];
          data_out_3 <= w_rd[2];
          if (r_beat_cnt == BW'(BEATS - 1)) begin
            frame_done        <= 1'b1;
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
            r_beat_cnt        <= '0;
            r_state           <= IDLE;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_flatten_buffer.sv
// Bench for fc_flatten_buffer: frame-level model plus directed vectors.
module tb_fc_flatten_buffer;
  localparam int FL = 48;
  localparam int NB = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        fc_ready;
  logic [15:0] data_out_1, data_out_2, data_out_3;
  logic        o_valid, frame_done, ovf_err;

  int total = 0;
  int bad   = 0;

  fc_flatten_buffer dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fc_ready  (fc_ready),
    .data_out_1(data_out_1),
    .data_out_2(data_out_2),
    .data_out_3(data_out_3),
    .o_valid   (o_valid),
    .frame_done(frame_done),
    .ovf_err   (ovf_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int u16(input logic [15:0] x);
    return int'({16'h0, x});
  endfunction

  // Model: frames are a FIFO of samples; a full frame becomes replayable,
  // at most two frames can be held, and each replays as 16 beats of 3.
  logic [15:0] pend_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_d [3];
  int  held, beat_idx, stall, beats_seen;
  bit  m_ovf, gap_req;

  initial beats_seen = 0;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      pend_q.delete();
      exp_q.delete();
      for (int k = 0; k < 3; k++) last_d[k] = '0;
      held = 0; beat_idx = 0; stall = 0; m_ovf = 0; gap_req = 0;
    end else begin
      if (o_valid) begin
        stall = 0;
        if (gap_req) chk("gap_between_frames", 1, 0);
        if (exp_q.size() < 3) begin
          chk("spurious_valid", 1, 0);
        end else begin
          for (int k = 0; k < 3; k++) last_d[k] = exp_q.pop_front();
          chk("beat_d1", u16(data_out_1), u16(last_d[0]));
          chk("beat_d2", u16(data_out_2), u16(last_d[1]));
          chk("beat_d3", u16(data_out_3), u16(last_d[2]));
          chk("frame_done", int'(frame_done), int'(beat_idx == NB - 1));
          beats_seen++;
          beat_idx++;
        end
        gap_req = 0;
        if (beat_idx == NB) begin
          beat_idx = 0;
          held--;
          gap_req = 1;
        end
      end else begin
        gap_req = 0;
        chk("idle_frame_done", int'(frame_done), 0);
        chk("hold_d1", u16(data_out_1), u16(last_d[0]));
        chk("hold_d2", u16(data_out_2), u16(last_d[1]));
        chk("hold_d3", u16(data_out_3), u16(last_d[2]));
        if (beat_idx == 0 && exp_q.size() >= FL && fc_ready) begin
          stall++;
          if (stall > 2) begin
            chk("stream_start_late", 0, 1);
            stall = 0;
          end
        end else begin
          stall = 0;
        end
      end
      chk("in_ready", int'(in_ready), int'(held < 2));
      chk("ovf_err", int'(ovf_err), int'(m_ovf));
      if (in_valid) begin
        if (held < 2) begin
          pend_q.push_back(in_data);
          if (pend_q.size() == FL) begin
            for (int k = 0; k < FL; k++) exp_q.push_back(pend_q[k]);
            pend_q.delete();
            held++;
          end
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge i_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk); #1 i_rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_valid) done = 1;
    end
    if (!done) chk(name, 0, 1);
  endtask

  task automatic wait_frame_done(input string name);
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge i_clk);
      if (frame_done) done = 1;
    end
    if (!done) chk(name, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    in_valid = 1'b0; in_data = '0; fc_ready = 1'b0; i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;

    // reset state
    @(negedge i_clk);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_d1", u16(data_out_1), 0);
    chk("rst_d2", u16(data_out_2), 0);
    chk("rst_d3", u16(data_out_3), 0);

    // single frame, first-beat latency and last beat
    @(posedge i_clk); #1 fc_ready = 1'b1;
    b0 = beats_seen;
    for (int i = 1; i <= FL; i++) push(16'(i));
    @(negedge i_clk);
    chk("start_not_early", int'(o_valid), 0);
    @(negedge i_clk);
    chk("start_valid", int'(o_valid), 1);
    chk("beat0_d1", u16(data_out_1), 1);
    chk("beat0_d2", u16(data_out_2), 2);
    chk("beat0_d3", u16(data_out_3), 3);
    chk("beat0_no_done", int'(frame_done), 0);
    repeat (15) @(negedge i_clk);
    chk("beat15_valid", int'(o_valid), 1);
    chk("beat15_d1", u16(data_out_1), 46);
    chk("beat15_d2", u16(data_out_2), 47);
    chk("beat15_d3", u16(data_out_3), 48);
    chk("beat15_done", int'(frame_done), 1);
    @(negedge i_clk);
    chk("after_frame_low", int'(o_valid), 0);
    wait_idle("single_timeout");
    chk("single_beats", beats_seen - b0, 16);

    // sign pass-through
    push(16'h8000); push(16'hFFFF); push(16'h7FFF);
    for (int i = 3; i < FL; i++) push(16'(i * 1000 - 20000));
    @(negedge i_clk); @(negedge i_clk);
    chk("sign_d1", u16(data_out_1), 32'h8000);
    chk("sign_d2", u16(data_out_2), 32'hFFFF);
    chk("sign_d3", u16(data_out_3), 32'h7FFF);
    wait_idle("sign_timeout");

    // backpressure: both banks fill, 97th sample overflows
    @(posedge i_clk); #1 fc_ready = 1'b0;
    b0 = beats_seen;
    for (int i = 1; i <= 2 * FL; i++) push(16'(i));
    @(negedge i_clk);
    chk("full_in_ready", int'(in_ready), 0);
    push(16'd97);
    @(negedge i_clk);
    chk("ovf_set", int'(ovf_err), 1);
    chk("held_no_valid", int'(o_valid), 0);
    @(posedge i_clk); #1 fc_ready = 1'b1;
    wait_frame_done("bp_frame1_timeout");
    chk("bp_free_in_ready", int'(in_ready), 1);
    chk("bp_last_d3", u16(data_out_3), 48);
    wait_idle("bp_timeout");
    chk("bp_beats", beats_seen - b0, 32);
    chk("ovf_sticky", int'(ovf_err), 1);

    // continuous: three frames back to back
    do_reset();
    b0 = beats_seen;
    for (int i = 0; i < 3 * FL; i++) push(16'(1000 + i));
    wait_idle("cont_timeout");
    chk("cont_beats", beats_seen - b0, 48);
    chk("cont_no_ovf", int'(ovf_err), 0);

    // reset during beat 7
    for (int i = 1; i <= FL; i++) push(16'(200 + i));
    repeat (8) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_d1", u16(data_out_1), 0);
    chk("mid_rst_d2", u16(data_out_2), 0);
    chk("mid_rst_d3", u16(data_out_3), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    for (int i = 1; i <= FL; i++) push(16'(300 + i));
    @(negedge i_clk); @(negedge i_clk);
    chk("post_rst_d1", u16(data_out_1), 301);
    chk("post_rst_d2", u16(data_out_2), 302);
    chk("post_rst_d3", u16(data_out_3), 303);
    wait_idle("post_rst_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
